// File: rtl/cntr_param_computational_pkg.sv
// -----------------------------------------------------------------------------
// cntr_operations
// Shared command encodings for the counter family.
//   cntr_operations_t  : original 2-bit opcode of the fixed 32-bit counter.
//   cntr_param_ops_t   : 3-bit opcode of the parametrised counter datapath.
//                        Codes 6 and 7 are unassigned and act as NOP.
//   CNTR_OP_W          : width of cntr_param_ops_t.
// -----------------------------------------------------------------------------
package cntr_operations;

    typedef enum logic [1:0] {
        CNTR_NOP     = 2'd0,
        CNTR_CLEAR   = 2'd1,
        CNTR_INC     = 2'd2,
        CNTR_PUBLISH = 2'd3
    } cntr_operations_t;

    localparam int CNTR_OP_W = 3;

    typedef enum logic [CNTR_OP_W-1:0] {
        CNTR_P_NOP     = 3'd0,
        CNTR_P_CLEAR   = 3'd1,
        CNTR_P_INC     = 3'd2,
        CNTR_P_PUBLISH = 3'd3,
        CNTR_P_DEC     = 3'd4,
        CNTR_P_LOAD    = 3'd5
    } cntr_param_ops_t;

endpackage

// File: rtl/cntr_param_computational_next.sv
// -----------------------------------------------------------------------------
// cntr_param_next
// Purely combinational next-state function of the parametrised counter.
// Ports:
//   i_count     : current count register value
//   i_operation : command (cntr_param_ops_t), unknown codes behave as NOP
//   i_load_val  : value for LOAD, clipped to MAX_VAL
//   o_next      : next count value
//   o_wrap      : INC/DEC crossed a boundary (wrapped or clamped)
//   o_pub       : command updates the published count
// All arithmetic is carried at WIDTH+1 bits so boundary checks see the true
// sum/difference before any truncation.
// -----------------------------------------------------------------------------
module cntr_param_next
    import cntr_operations::*;
#(
    parameter int unsigned     WIDTH    = 32,
    parameter longint unsigned STEP     = 1,
    parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
    parameter bit              SATURATE = 1'b0
) (
    input  logic [WIDTH-1:0] i_count,
    input  cntr_param_ops_t  i_operation,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_next,
    output logic             o_wrap,
    output logic             o_pub
);

    localparam logic [WIDTH:0] C_STEP = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0] C_MAX  = (WIDTH+1)'(MAX_VAL);
    // Modulus MAX_VAL+1 can be 2**WIDTH, hence the extra bit.
    localparam logic [WIDTH:0] C_MOD  = C_MAX + 1'b1;

    logic [WIDTH:0] w_cnt_x;
    logic [WIDTH:0] w_load_x;
    logic [WIDTH:0] w_sum;
    logic           w_inc_over;
    logic           w_dec_under;

    assign w_cnt_x     = {1'b0, i_count};
    assign w_load_x    = {1'b0, i_load_val};
    assign w_sum       = w_cnt_x + C_STEP;
    assign w_inc_over  = (w_sum > C_MAX);
    assign w_dec_under = (w_cnt_x < C_STEP);

    always_comb begin
        o_next = i_count;
        o_wrap = 1'b0;
        o_pub  = 1'b0;
        case (i_operation)
            CNTR_P_CLEAR: begin
                o_next = '0;
                o_pub  = 1'b1;
            end
            CNTR_P_INC: begin
                o_pub  = 1'b1;
                o_wrap = w_inc_over;
                if (!w_inc_over) begin
                    o_next = WIDTH'(w_sum);
                end else if (SATURATE) begin
                    o_next = WIDTH'(C_MAX);
                end else begin
                    o_next = WIDTH'(w_sum - C_MOD);
                end
            end
            CNTR_P_DEC: begin
                o_pub  = 1'b1;
                o_wrap = w_dec_under;
                if (!w_dec_under) begin
                    o_next = WIDTH'(w_cnt_x - C_STEP);
                end else if (SATURATE) begin
                    o_next = '0;
                end else begin
                    // count < STEP <= MAX_VAL, so count+MOD stays inside WIDTH+1 bits
                    o_next = WIDTH'(w_cnt_x + C_MOD - C_STEP);
                end
            end
            CNTR_P_LOAD: begin
                o_pub  = 1'b1;
                o_next = (w_load_x > C_MAX) ? WIDTH'(C_MAX) : i_load_val;
            end
            CNTR_P_PUBLISH: begin
                o_pub = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/cntr_param_computational.sv
// -----------------------------------------------------------------------------
// cntr_param_computational
// Parametrised counter datapath: clear / inc / dec / load / publish with
// modulo-wrap or saturating behaviour and boundary flags.
// Optional build macro: CNTR_OVF_STICKY_EN -- when defined, ovf_sticky latches
// any wrap/clamp event until CLEAR or reset; when undefined it is tied to 0.
// Ports:
//   clk           : clock, rising edge
//   rst           : asynchronous active-low reset
//   en_sig        : qualifies operation; 0 = hold everything, pulses 0
//   operation     : command (cntr_param_ops_t)
//   load_val      : LOAD value (clipped to MAX_VAL)
//   cnt_out_t_out : internal count register
//   cnt_out_sig   : registered published count
//   pub_valid     : 1-cycle pulse, cnt_out_sig updated
//   wrap_evt      : 1-cycle pulse, INC/DEC crossed a boundary
//   at_max        : count == MAX_VAL
//   at_zero       : count == 0
//   ovf_sticky    : sticky wrap indicator (see macro above)
// -----------------------------------------------------------------------------
module cntr_param_computational
    import cntr_operations::*;
#(
    parameter int unsigned     WIDTH    = 32,
    parameter longint unsigned STEP     = 1,
    parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
    parameter bit              SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_sig,
    input  cntr_param_ops_t  operation,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt_out_t_out,
    output logic [WIDTH-1:0] cnt_out_sig,
    output logic             pub_valid,
    output logic             wrap_evt,
    output logic             at_max,
    output logic             at_zero,
    output logic             ovf_sticky
);

    // Shifting a 64-bit one by 64 gives 0, so the subtraction yields all ones.
    localparam longint unsigned C_LIMIT = (64'd1 << WIDTH) - 64'd1;

    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("cntr_param_computational: WIDTH must be in 1..64");
    end
    if (MAX_VAL < 1 || MAX_VAL > C_LIMIT) begin : g_bad_max
        $error("cntr_param_computational: MAX_VAL must be in 1..2**WIDTH-1");
    end
    if (STEP < 1 || STEP > MAX_VAL) begin : g_bad_step
        $error("cntr_param_computational: STEP must be in 1..MAX_VAL");
    end

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_pub;
    logic             r_pub_valid;
    logic             r_wrap_evt;

    logic [WIDTH-1:0] w_next;
    logic             w_wrap;
    logic             w_pub;

    cntr_param_next #(
        .WIDTH    (WIDTH),
        .STEP     (STEP),
        .MAX_VAL  (MAX_VAL),
        .SATURATE (SATURATE)
    ) u_next (
        .i_count     (r_count),
        .i_operation (operation),
        .i_load_val  (load_val),
        .o_next      (w_next),
        .o_wrap      (w_wrap),
        .o_pub       (w_pub)
    );

    // NOP / unknown codes return next == count with no pulses, so applying
    // w_next unconditionally under en_sig is safe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count     <= '0;
            r_pub       <= '0;
            r_pub_valid <= 1'b0;
            r_wrap_evt  <= 1'b0;
        end else begin
            r_pub_valid <= en_sig & w_pub;
            r_wrap_evt  <= en_sig & w_wrap;
            if (en_sig) begin
                r_count <= w_next;
                if (w_pub) begin
                    r_pub <= w_next;
                end
            end
        end
    end

`ifdef CNTR_OVF_STICKY_EN
    logic r_ovf_sticky;

    // CLEAR and a wrap are mutually exclusive opcodes; CLEAR is checked first anyway.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf_sticky <= 1'b0;
        end else if (en_sig && (operation == CNTR_P_CLEAR)) begin
            r_ovf_sticky <= 1'b0;
        end else if (en_sig && w_wrap) begin
            r_ovf_sticky <= 1'b1;
        end
    end

    assign ovf_sticky = r_ovf_sticky;
`else
    assign ovf_sticky = 1'b0;
`endif

    assign cnt_out_t_out = r_count;
    assign cnt_out_sig   = r_pub;
    assign pub_valid     = r_pub_valid;
    assign wrap_evt      = r_wrap_evt;
    assign at_max        = (r_count == WIDTH'(MAX_VAL));
    assign at_zero       = (r_count == '0);

endmodule

// File: tb/tb_cntr_param_computational.sv
// -----------------------------------------------------------------------------
// Bench for cntr_param_computational: two instances (wrap and saturate) with
// WIDTH=8, MAX_VAL=9, STEP=3 share one stimulus stream. A reference model
// pushes expected outputs into per-instance queues; a monitor pops and
// compares one entry after each clock edge that follows a command.
// -----------------------------------------------------------------------------
module tb_cntr_param_computational;
    import cntr_operations::*;

    localparam int W    = 8;
    localparam int MAXV = 9;
    localparam int STP  = 3;

    typedef struct {
        int cnt;
        int pub;
        bit pv;
        bit we;
        bit amax;
        bit azero;
        bit ovf;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            en_sig = 1'b0;
    cntr_param_ops_t operation = CNTR_P_NOP;
    logic [W-1:0]    load_val = '0;

    logic [W-1:0] c0, p0, c1, p1;
    logic         pv0, we0, am0, az0, ov0;
    logic         pv1, we1, am1, az1, ov1;

    int total = 0;
    int bad   = 0;
    int txn   = 0;

    exp_t q0[$];
    exp_t q1[$];

    int m_cnt[2];
    int m_pub[2];
    bit m_ovf[2];

    always #5 clk = ~clk;

    cntr_param_computational #(
        .WIDTH(W), .STEP(64'(STP)), .MAX_VAL(64'(MAXV)), .SATURATE(1'b0)
    ) u_wrap (
        .clk(clk), .rst(rst), .en_sig(en_sig), .operation(operation), .load_val(load_val),
        .cnt_out_t_out(c0), .cnt_out_sig(p0), .pub_valid(pv0), .wrap_evt(we0),
        .at_max(am0), .at_zero(az0), .ovf_sticky(ov0)
    );

    cntr_param_computational #(
        .WIDTH(W), .STEP(64'(STP)), .MAX_VAL(64'(MAXV)), .SATURATE(1'b1)
    ) u_sat (
        .clk(clk), .rst(rst), .en_sig(en_sig), .operation(operation), .load_val(load_val),
        .cnt_out_t_out(c1), .cnt_out_sig(p1), .pub_valid(pv1), .wrap_evt(we1),
        .at_max(am1), .at_zero(az1), .ovf_sticky(ov1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    // Reference model: spec arithmetic on plain integers.
    task automatic model_step(input int k, input bit sat, input bit en, input int op,
                              input int lv, output exp_t e);
        bit pv = 1'b0;
        bit we = 1'b0;
        int s;
        if (en) begin
            case (op)
                1: begin m_cnt[k] = 0; m_pub[k] = 0; pv = 1'b1; m_ovf[k] = 1'b0; end
                2: begin
                    s = m_cnt[k] + STP;
                    if (s > MAXV) begin
                        we = 1'b1;
                        m_cnt[k] = sat ? MAXV : s - (MAXV + 1);
                    end else begin
                        m_cnt[k] = s;
                    end
                    m_pub[k] = m_cnt[k]; pv = 1'b1;
                end
                3: begin m_pub[k] = m_cnt[k]; pv = 1'b1; end
                4: begin
                    if (m_cnt[k] < STP) begin
                        we = 1'b1;
                        m_cnt[k] = sat ? 0 : m_cnt[k] + MAXV + 1 - STP;
                    end else begin
                        m_cnt[k] = m_cnt[k] - STP;
                    end
                    m_pub[k] = m_cnt[k]; pv = 1'b1;
                end
                5: begin
                    m_cnt[k] = (lv > MAXV) ? MAXV : lv;
                    m_pub[k] = m_cnt[k]; pv = 1'b1;
                end
                default: begin end
            endcase
        end
`ifdef CNTR_OVF_STICKY_EN
        if (we) m_ovf[k] = 1'b1;
`endif
        e.cnt = m_cnt[k]; e.pub = m_pub[k]; e.pv = pv; e.we = we;
        e.amax = (m_cnt[k] == MAXV); e.azero = (m_cnt[k] == 0); e.ovf = m_ovf[k];
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_pub[k] = 0; m_ovf[k] = 1'b0;
        end
    endtask

    task automatic issue(input bit en, input int op, input int lv);
        exp_t e0, e1;
        logic [2:0] op3;
        @(negedge clk);
        op3 = op[2:0];
        en_sig    = en;
        operation = cntr_param_ops_t'(op3);
        load_val  = lv[W-1:0];
        model_step(0, 1'b0, en, op, lv, e0);
        model_step(1, 1'b1, en, op, lv, e1);
        q0.push_back(e0);
        q1.push_back(e1);
        @(posedge clk);
        #1 en_sig = 1'b0;
    endtask

    task automatic check_inst(input string tag, input exp_t e,
                              input logic [W-1:0] c, input logic [W-1:0] p,
                              input logic pv, input logic we, input logic am,
                              input logic az, input logic ov);
        chk({tag, ".count"},     32'(c),  32'(e.cnt));
        chk({tag, ".cnt_out"},   32'(p),  32'(e.pub));
        chk({tag, ".pub_valid"}, 32'(pv), 32'(e.pv));
        chk({tag, ".wrap_evt"},  32'(we), 32'(e.we));
        chk({tag, ".at_max"},    32'(am), 32'(e.amax));
        chk({tag, ".at_zero"},   32'(az), 32'(e.azero));
        chk({tag, ".ovf"},       32'(ov), 32'(e.ovf));
    endtask

    // Monitor: one queued expectation per command, compared just after its edge.
    initial begin
        forever begin
            exp_t a, b;
            @(posedge clk);
            #1;
            if (q0.size() > 0 && q1.size() > 0) begin
                a = q0.pop_front();
                b = q1.pop_front();
                txn++;
                $display("txn %0d: wrap cnt=%0d pub=%0d pv=%0b we=%0b | sat cnt=%0d pub=%0d pv=%0b we=%0b",
                         txn, c0, p0, pv0, we0, c1, p1, pv1, we1);
                check_inst("wrap", a, c0, p0, pv0, we0, am0, az0, ov0);
                check_inst("sat",  b, c1, p1, pv1, we1, am1, az1, ov1);
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".wrap.count"},   32'(c0),  0);
        chk({tag, ".wrap.cnt_out"}, 32'(p0),  0);
        chk({tag, ".wrap.pv"},      32'(pv0), 0);
        chk({tag, ".wrap.we"},      32'(we0), 0);
        chk({tag, ".wrap.at_max"},  32'(am0), 0);
        chk({tag, ".wrap.at_zero"}, 32'(az0), 1);
        chk({tag, ".wrap.ovf"},     32'(ov0), 0);
        chk({tag, ".sat.count"},    32'(c1),  0);
        chk({tag, ".sat.cnt_out"},  32'(p1),  0);
        chk({tag, ".sat.pv"},       32'(pv1), 0);
        chk({tag, ".sat.we"},       32'(we1), 0);
        chk({tag, ".sat.at_zero"},  32'(az1), 1);
        chk({tag, ".sat.ovf"},      32'(ov1), 0);
    endtask

    task automatic drain();
        @(posedge clk);
        #2;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1 chk_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        // Four INCs from zero: 3,6,9 then wrap (2) / clamp (9).
        repeat (4) issue(1'b1, 2, 0);
        // DEC across zero and a normal DEC.
        issue(1'b1, 5, 1);
        issue(1'b1, 4, 0);
        issue(1'b1, 4, 0);
        // Clipped LOAD, disabled INC, PUBLISH, unassigned opcodes.
        issue(1'b1, 5, 200);
        issue(1'b1, 4, 0);
        issue(1'b0, 2, 0);
        issue(1'b0, 5, 0);
        issue(1'b1, 3, 0);
        issue(1'b1, 6, 7);
        issue(1'b1, 7, 7);
        // Sticky flag holds through LOAD and INC, cleared by CLEAR.
        issue(1'b1, 5, 9);
        issue(1'b1, 2, 0);
        issue(1'b1, 5, 4);
        issue(1'b1, 2, 0);
        issue(1'b1, 1, 0);
        // Asynchronous reset mid-cycle while an INC is presented.
        issue(1'b1, 5, 6);
        drain();
        @(negedge clk);
        en_sig = 1'b1; operation = CNTR_P_INC;
        #2 rst = 1'b0;
        #1 chk_reset_outputs("async_rst");
        @(posedge clk);
        #1 chk_reset_outputs("rst_hold");
        @(negedge clk);
        en_sig = 1'b0;
        rst = 1'b1;
        model_reset();
        issue(1'b1, 2, 0);

        // Randomised traffic.
        for (int i = 0; i < 200; i++) begin
            int op, lv;
            bit en;
            en = ($urandom_range(0, 9) != 0);
            op = $urandom_range(0, 7);
            if (op == 1 && $urandom_range(0, 3) != 0) op = 2;
            lv = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 12) : $urandom_range(0, 255);
            issue(en, op, lv);
        end

        drain();
        chk("queue_drained", 32'(q0.size() + q1.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
